// File: rtl/hazard_forward_ctrl.sv
// Hazard detection and operand-forwarding control for an in-order pipeline.
// A tag pipeline follows each register-writing instruction from EX to WB.
// Each source operand of the ID-stage instruction is matched against the tags.
// On a match the block either selects a forward path or stalls until the result is ready.
module hazard_forward_ctrl #(
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 3,
    parameter int RA_W    = 5,
    localparam int SEL_W  = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_valid,
    input  logic                     issue_regwrite,
    input  logic [RA_W-1:0]          issue_rd,
    input  logic [SEL_W-1:0]         issue_rdy,
    input  logic [NUM_SRC*RA_W-1:0]  src_addr,
    input  logic [NUM_SRC-1:0]       src_use,
    input  logic                     flush,
    output logic                     stall,
    output logic [NUM_SRC*SEL_W-1:0] fwd_sel_ex,
    output logic [15:0]              stall_cnt
);

    // The WB entry T[DEPTH] is never matched and is retired on the next edge.
    // Only T[1..DEPTH-1] is therefore stored.
    localparam int TRK = DEPTH - 1;

    logic             tag_valid_q [1:TRK];
    logic [RA_W-1:0]  tag_rd_q    [1:TRK];
    logic [SEL_W-1:0] tag_rdy_q   [1:TRK];
    logic             tag_valid_d [1:TRK];
    logic [RA_W-1:0]  tag_rd_d    [1:TRK];
    logic [SEL_W-1:0] tag_rdy_d   [1:TRK];

    logic [NUM_SRC*SEL_W-1:0] fwd_q, fwd_d, fwd_cand;
    logic [15:0]              cnt_q, cnt_d;
    logic [NUM_SRC-1:0]       hazard;
    logic [SEL_W-1:0]         rdy_clamped;
    logic                     accept;

    // Clamp the producer's ready stage into the legal range [2, DEPTH]
    always_comb begin
        rdy_clamped = issue_rdy;
        if (int'(issue_rdy) < 2) begin
            rdy_clamped = SEL_W'(2);
        end else if (int'(issue_rdy) > DEPTH) begin
            rdy_clamped = SEL_W'(DEPTH);
        end
    end

    // Per-source match against tags. The scan runs oldest to youngest, so the youngest match is written last and wins.
    always_comb begin
        fwd_cand = '0;
        hazard   = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            for (int unsigned k = TRK; k >= 1; k--) begin
                if (src_use[i] && (src_addr[i*RA_W +: RA_W] != '0) &&
                    tag_valid_q[k] && (tag_rd_q[k] == src_addr[i*RA_W +: RA_W])) begin
                    fwd_cand[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
                    hazard[i]                  = (SEL_W'(k + 1) < tag_rdy_q[k]);
                end
            end
        end
    end

    // Stall and issue acceptance. A flush suppresses any stall.
    always_comb begin
        stall  = issue_valid && !flush && (|hazard);
        accept = issue_valid && !stall && !flush;
    end

    // Next state for the tag pipeline, the EX forward selects and the stall counter
    always_comb begin
        tag_valid_d[1] = accept && issue_regwrite && (issue_rd != '0);
        tag_rd_d[1]    = issue_rd;
        tag_rdy_d[1]   = rdy_clamped;
        for (int unsigned k = 2; k <= TRK; k++) begin
            tag_valid_d[k] = tag_valid_q[k-1];
            tag_rd_d[k]    = tag_rd_q[k-1];
            tag_rdy_d[k]   = tag_rdy_q[k-1];
        end
        fwd_d = accept ? fwd_cand : '0;
        cnt_d = cnt_q;
        if (stall && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // State registers. The reset is asynchronous and discards all in-flight tags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_valid_q <= '{default: '0};
            tag_rd_q    <= '{default: '0};
            tag_rdy_q   <= '{default: '0};
            fwd_q       <= '0;
            cnt_q       <= '0;
        end else begin
            tag_valid_q <= tag_valid_d;
            tag_rd_q    <= tag_rd_d;
            tag_rdy_q   <= tag_rdy_d;
            fwd_q       <= fwd_d;
            cnt_q       <= cnt_d;
        end
    end

    assign fwd_sel_ex = fwd_q;
    assign stall_cnt  = cnt_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Scoreboard bench for hazard_forward_ctrl with DEPTH=3, NUM_SRC=2 and RA_W=5.
// Each step drives one ID-stage instruction and checks the combinational stall.
// The expected registered outputs are queued and compared after the clock edge.
module tb_hazard_forward_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid, issue_regwrite, flush;
    logic [4:0]  issue_rd;
    logic [1:0]  issue_rdy;
    logic [9:0]  src_addr;
    logic [1:0]  src_use;
    logic        stall;
    logic [3:0]  fwd_sel_ex;
    logic [15:0] stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       tag;
        logic [3:0]  fwd;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb_q[$];

    hazard_forward_ctrl #(.NUM_SRC(2), .DEPTH(3), .RA_W(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .issue_valid    (issue_valid),
        .issue_regwrite (issue_regwrite),
        .issue_rd       (issue_rd),
        .issue_rdy      (issue_rdy),
        .src_addr       (src_addr),
        .src_use        (src_use),
        .flush          (flush),
        .stall          (stall),
        .fwd_sel_ex     (fwd_sel_ex),
        .stall_cnt      (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one ID instruction at the negedge, then check stall before the edge and the registered outputs after it
    task automatic step(input string tag, input logic v, input logic rw, input logic [4:0] rd,
                        input logic [1:0] rdy, input logic [4:0] s0, input logic [4:0] s1,
                        input logic [1:0] use_v, input logic fl, input logic exp_stall,
                        input logic [3:0] exp_fwd, input logic [15:0] exp_cnt);
        exp_t e;
        issue_valid    = v;
        issue_regwrite = rw;
        issue_rd       = rd;
        issue_rdy      = rdy;
        src_addr       = {s1, s0};
        src_use        = use_v;
        flush          = fl;
        #1;
        check_eq({tag, ".stall"}, 32'(stall), 32'(exp_stall));
        sb_q.push_back('{tag, exp_fwd, exp_cnt});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_eq({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_eq({e.tag, ".fwd"}, 32'(fwd_sel_ex), 32'(e.fwd));
            check_eq({e.tag, ".cnt"}, 32'(stall_cnt), 32'(e.cnt));
        end
        @(negedge clk);
    endtask

    initial begin
        rst            = 1'b1;
        issue_valid    = 1'b0;
        issue_regwrite = 1'b0;
        issue_rd       = '0;
        issue_rdy      = '0;
        src_addr       = '0;
        src_use        = '0;
        flush          = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rst.stall", 32'(stall), 32'd0);
        check_eq("rst.fwd",   32'(fwd_sel_ex), 32'd0);
        check_eq("rst.cnt",   32'(stall_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        //   tag           v   rw  rd  rdy  s0  s1  use    fl  stall fwd{f1,f0} cnt
        step("alu5",       1, 1, 5,  2, 0,  0,  2'b00, 0, 0, 4'b0000, 16'd0);
        step("alu_fwd",    1, 0, 0,  2, 5,  0,  2'b01, 0, 0, 4'b0010, 16'd0);
        step("ld6",        1, 1, 6,  3, 0,  0,  2'b00, 0, 0, 4'b0000, 16'd0);
        step("ldu_stall",  1, 0, 0,  2, 0,  6,  2'b10, 0, 1, 4'b0000, 16'd1);
        step("ldu_fwd",    1, 0, 0,  2, 0,  6,  2'b10, 0, 0, 4'b1100, 16'd1);
        step("alu7a",      1, 1, 7,  2, 0,  0,  2'b00, 0, 0, 4'b0000, 16'd1);
        step("alu7b",      1, 1, 7,  2, 0,  0,  2'b00, 0, 0, 4'b0000, 16'd1);
        step("youngest",   1, 0, 0,  2, 7,  0,  2'b01, 0, 0, 4'b0010, 16'd1);
        step("alu8",       1, 1, 8,  2, 0,  0,  2'b00, 0, 0, 4'b0000, 16'd1);
        step("nouse",      1, 0, 0,  2, 1,  8,  2'b01, 0, 0, 4'b0000, 16'd1);
        step("ld_x0",      1, 1, 0,  3, 0,  0,  2'b00, 0, 0, 4'b0000, 16'd1);
        step("x0_use",     1, 0, 0,  2, 0,  0,  2'b11, 0, 0, 4'b0000, 16'd1);
        step("alu20_rdy0", 1, 1, 20, 0, 0,  0,  2'b00, 0, 0, 4'b0000, 16'd1);
        step("clamp_use",  1, 0, 0,  2, 20, 0,  2'b01, 0, 0, 4'b0010, 16'd1);
        step("ld9",        1, 1, 9,  3, 0,  0,  2'b00, 0, 0, 4'b0000, 16'd1);
        step("flush",      1, 1, 10, 2, 9,  0,  2'b01, 1, 0, 4'b0000, 16'd1);
        step("flush_bub",  1, 0, 0,  2, 10, 0,  2'b01, 0, 0, 4'b0000, 16'd1);
        step("ld11",       1, 1, 11, 3, 0,  0,  2'b00, 0, 0, 4'b0000, 16'd1);
        step("dual_stall", 1, 0, 0,  2, 11, 11, 2'b11, 0, 1, 4'b0000, 16'd2);
        step("dual_fwd",   1, 0, 0,  2, 11, 11, 2'b11, 0, 0, 4'b1111, 16'd2);
        step("alu14",      1, 1, 14, 2, 0,  0,  2'b00, 0, 0, 4'b0000, 16'd2);
        step("ld13",       1, 1, 13, 3, 14, 0,  2'b01, 0, 0, 4'b0010, 16'd2);

        // A consumer of x13 would stall. Reset is pulsed between edges while the load is in flight.
        issue_valid    = 1'b1;
        issue_regwrite = 1'b0;
        src_addr       = {5'd0, 5'd13};
        src_use        = 2'b01;
        #1;
        check_eq("pre_rst.stall", 32'(stall), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("in_rst.stall", 32'(stall), 32'd0);
        check_eq("in_rst.fwd",   32'(fwd_sel_ex), 32'd0);
        check_eq("in_rst.cnt",   32'(stall_cnt), 32'd0);
        rst = 1'b0;
        step("post_rst",   1, 0, 0,  2, 13, 0,  2'b01, 0, 0, 4'b0000, 16'd0);
        step("post_ld",    1, 1, 15, 3, 0,  0,  2'b00, 0, 0, 4'b0000, 16'd0);
        step("post_stall", 1, 0, 0,  2, 15, 0,  2'b01, 0, 1, 4'b0000, 16'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_forward_ctrl.md
HAZARD_FORWARD_CTRL -- requirements
Module: hazard_forward_ctrl

Interface
REQ-001 Parameter NUM_SRC, default 2, SHALL set the number of source-operand ports; typically rs1, rs2 and store data.
REQ-002 Parameter DEPTH, default 3, SHALL set the number of tracked stages after ID; stage 1 = EX, stage DEPTH = WB.
REQ-003 Parameter RA_W, default 5, SHALL set the register-address width.
REQ-004 Derived SEL_W = clog2(DEPTH+1) SHALL be the width of each forward select.
REQ-005 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 issue_valid  input  1  the ID-stage instruction is valid.
REQ-008 issue_regwrite  input  1  the ID-stage instruction writes a register.
REQ-009 issue_rd  input  RA_W  destination register of the ID-stage instruction.
REQ-010 issue_rdy  input  SEL_W  first stage whose output register carries the result; 2 = ALU, 3 = load.
REQ-011 src_addr  input  NUM_SRC*RA_W  packed source addresses of the ID-stage instruction; source i occupies bits [i*RA_W +: RA_W].
REQ-012 src_use  input  NUM_SRC  per-source "operand actually read" flag; 0 for an immediate or an unused source.
REQ-013 flush  input  1  kills the ID-stage instruction.
REQ-014 stall  output  1  combinational; holds IF/ID and inserts a bubble into EX.
REQ-015 fwd_sel_ex  output  NUM_SRC*SEL_W  registered; one select per source for the instruction now in EX; 0 = register file, s = forward from the output of stage s.
REQ-016 stall_cnt  output  16  registered; saturating count of stall cycles.

Function
REQ-017 Tag pipeline T[1..DEPTH]: each entry SHALL hold {valid, rd, rdy}.
REQ-018 On every edge, T[k+1] SHALL take T[k] for k = 1..DEPTH-1, and T[DEPTH] SHALL be discarded because it is retired to the register file.
REQ-019 T[1] SHALL load {1, issue_rd, clamp(issue_rdy)} only when issue_valid && issue_regwrite && issue_rd != 0 && !stall && !flush; otherwise T[1] SHALL load a bubble (valid = 0).
REQ-020 clamp(issue_rdy) SHALL map values below 2 to 2 and values above DEPTH to DEPTH.
REQ-021 Match for source i against T[k]: src_use[i] && src_addr_i != 0 && T[k].valid && T[k].rd == src_addr_i, for k = 1..DEPTH-1 only; T[DEPTH] is never matched.
REQ-022 The youngest match (smallest k) SHALL win, and the candidate stage SHALL be s = k+1, the producer's stage on the next cycle.
REQ-023 Hazard for source i SHALL be flagged when the winning match has s < T[k].rdy.
REQ-024 stall SHALL equal issue_valid && !flush && (OR of all hazards over i), evaluated combinationally in the same cycle.
REQ-025 flush SHALL take priority over stall; flush = 1 forces stall = 0.
REQ-026 On an edge with issue_valid && !stall && !flush, each fwd_sel_ex field SHALL load s of the winning match, or 0 if there is no match.
REQ-027 On any other edge, all fwd_sel_ex fields SHALL load 0, which is the bubble value.
REQ-028 stall_cnt SHALL increment by 1 on each edge where stall = 1 and SHALL hold at 16'hFFFF with no wrap-around.
REQ-029 A producer and a consumer with rd = src = x0 SHALL never forward and never stall.
REQ-030 Simultaneous load-use hazards on several sources SHALL produce a single stall cycle when the producers share the same rdy.

Reset
REQ-031 While rst = 1, regardless of clk, all T[k].valid SHALL clear, fwd_sel_ex SHALL be 0, and stall_cnt SHALL be 0.
REQ-032 The combinational stall output SHALL be 0 during reset because no valid tags exist.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight tags.
REQ-034 After release, the first edge SHALL behave as from an empty pipeline.

Verification (DEPTH = 3, NUM_SRC = 2)
REQ-035 ALU-to-ALU: ALU x5 (rdy 2) issued at cycle 0, consumer with src0 = x5 at cycle 1 -> stall = 0; after the edge, fwd_sel_ex[0] = 2.
REQ-036 Load-use: load x6 (rdy 3), then consumer with src1 = x6 -> stall = 1 for exactly one cycle and stall_cnt = 1; on the following edge, fwd_sel_ex[1] = 3.
REQ-037 Youngest wins: x7 written by two consecutive ALU ops, then consumer with src0 = x7 -> fwd_sel_ex[0] = 2, not 3.
REQ-038 No-forward cases -> src_use[1] = 0 with a matching rd gives fwd_sel_ex[1] = 0, and a producer with rd = x0 gives fwd_sel_ex = 0; stall = 0 in both cases.
REQ-039 Flush over hazard: load-use condition with flush = 1 -> stall = 0, a bubble enters T[1], fwd_sel_ex = 0, stall_cnt unchanged.
REQ-040 Async reset: rst pulsed between clock edges while T holds a load -> fwd_sel_ex = 0 and stall_cnt = 0 immediately; after release, a consumer of that register gets stall = 0 and fwd_sel_ex = 0.
